hazard_unit_mc: RTL

- Parametrised successor to the 5-stage pipeline hazard unit (F/D/E/M/W).
- Compares register addresses internally instead of taking precomputed match flags.
- Generates forwarding selects, load-use stalls and branch/PC-write flushes.
- Adds a multi-cycle execute (multiplier) occupancy FSM and D-stage stall/flush priority resolution.

---
 rtl/hazard_unit_mc_pkg.sv | 23 ++
 rtl/hazard_unit_mc_mul_stall_ctrl.sv | 77 +++++++
 rtl/hazard_unit_mc.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc_pkg
//   Shared definitions for the 5-stage pipeline hazard unit (F/D/E/M/W):
//   forwarding-select encodings, the multi-cycle FSM state type and the
//   width of the multi-cycle occupancy counter.
// -----------------------------------------------------------------------------
package hazard_unit_mc_pkg;

  // Forwarding mux selects for the E-stage operands.
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB   = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_MEM  = 2'b10;  // M-stage result

  // Multi-cycle execute occupancy FSM.
  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mcState_t;

  // Occupancy counter width; holds MUL_LAT-2 for MUL_LAT up to 16.
  localparam int CNT_W = 4;

endpackage

// File: rtl/hazard_unit_mc_mul_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mul_stall_ctrl
//   Tracks how long a multi-cycle (multiplier) op has occupied the E stage
//   and requests a pipeline hold until it has been there MUL_LAT cycles.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-low reset
//     MulStartE  in   E holds a multi-cycle op
//     mulStall   out  hold F/D/E this cycle (op stays in E)
//     MulBusy    out  FSM is in BUSY (op is past its first E cycle)
//
//   The first E cycle is spent in IDLE (the start is seen combinationally),
//   so the counter is loaded with MUL_LAT-2 and the op leaves E on the
//   cycle BUSY sees cnt==0. MUL_LAT==1 never leaves IDLE.
// -----------------------------------------------------------------------------
module mul_stall_ctrl
  import hazard_unit_mc_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic MulStartE,
  output logic mulStall,
  output logic MulBusy
);

  localparam bit                MULTI_CYCLE = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0]  START_CNT   = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  mcState_t         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mulStall  = 1'b0;
    case (state)
      MC_IDLE: begin
        if (MulStartE && MULTI_CYCLE) begin
          mulStall  = 1'b1;
          cntNext   = START_CNT;
          stateNext = MC_BUSY;
        end
      end
      MC_BUSY: begin
        if (cnt != '0) begin
          mulStall = 1'b1;
          cntNext  = cnt - CNT_W'(1);
        end else begin
          // Final E cycle: the op advances at this edge. A MulStartE seen
          // now belongs to the same op, so it is not treated as a new start.
          stateNext = MC_IDLE;
        end
      end
      default: stateNext = MC_IDLE;
    endcase
  end

  assign MulBusy = (state == MC_BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc
//   Hazard unit for a 5-stage pipeline (F/D/E/M/W) with a multi-cycle execute
//   unit. Compares register addresses to select forwarding, detects
//   load-use hazards, handles PC-writing instructions and taken branches,
//   and resolves the stall/flush priorities at D and E while a multi-cycle
//   op is held in E.
//
//   Ports:
//     clk, reset                      clock, asynchronous active-low reset
//     Ra1D, Ra2D / Ra1E, Ra2E         source registers of D / E instruction
//     WA3E, WA3M, WA3W                destination register in E / M / W
//     RegWriteE/M/W                   write enables
//     MemtoRegE                       E holds a load
//     BranchTakenE                    branch resolved taken in E
//     PCSrcD/E/M/W                    instruction in that stage writes PC
//     MulStartE                       E holds a multi-cycle op
//     StatClr                         synchronous clear of the statistics
//     ForwardAE, ForwardBE            00 regfile, 01 W result, 10 M result
//     StallF, StallD, StallE          hold pipeline registers
//     FlushD, FlushE, FlushM          bubble pipeline registers at next edge
//     MulBusy                         multi-cycle FSM not IDLE
//     StallCnt, FlushCnt              saturating statistics counters
//
//   Build option: define HAZARD_STAT_EN to include the statistics counters;
//   otherwise StallCnt/FlushCnt are constant zero and StatClr is ignored.
// -----------------------------------------------------------------------------
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int PC_REG     = 15,
  parameter int MUL_LAT    = 3,
  parameter int STAT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Ra1D,
  input  logic [REG_ADDR_W-1:0] Ra2D,
  input  logic [REG_ADDR_W-1:0] Ra1E,
  input  logic [REG_ADDR_W-1:0] Ra2E,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic [REG_ADDR_W-1:0] WA3M,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  BranchTakenE,
  input  logic                  PCSrcD,
  input  logic                  PCSrcE,
  input  logic                  PCSrcM,
  input  logic                  PCSrcW,
  input  logic                  MulStartE,
  input  logic                  StatClr,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  MulBusy,
  output logic [STAT_W-1:0]     StallCnt,
  output logic [STAT_W-1:0]     FlushCnt
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

  logic mulStall;
  logic ldrStall;
  logic pcWrPending;
  logic branchEff;

  mul_stall_ctrl #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_stall_ctrl (
    .clk       (clk),
    .reset     (reset),
    .MulStartE (MulStartE),
    .mulStall  (mulStall),
    .MulBusy   (MulBusy)
  );

  // Forwarding: the newer M result wins over W. The PC is not held in the
  // register file pipeline, so reads of it always come from the regfile path.
  always_comb begin
    ForwardAE = FWD_NONE;
    if (Ra1E != PC_ADDR) begin
      if (RegWriteM && (Ra1E == WA3M))      ForwardAE = FWD_MEM;
      else if (RegWriteW && (Ra1E == WA3W)) ForwardAE = FWD_WB;
    end
  end

  always_comb begin
    ForwardBE = FWD_NONE;
    if (Ra2E != PC_ADDR) begin
      if (RegWriteM && (Ra2E == WA3M))      ForwardBE = FWD_MEM;
      else if (RegWriteW && (Ra2E == WA3W)) ForwardBE = FWD_WB;
    end
  end

  assign ldrStall    = MemtoRegE & RegWriteE & ((Ra1D == WA3E) | (Ra2D == WA3E));
  assign pcWrPending = PCSrcD | PCSrcE | PCSrcM;

  // While a multi-cycle op owns E, a BranchTakenE in the same slot is stale.
  assign branchEff = BranchTakenE & ~MulBusy;

  assign StallF = ldrStall | pcWrPending | mulStall;
  assign StallD = ldrStall | mulStall;
  assign StallE = mulStall;

  // A held multi-cycle op is never killed, and a stalled D instruction is
  // preserved; the D flush reasserts once the stall drops.
  assign FlushM = mulStall;
  assign FlushE = (ldrStall | branchEff) & ~mulStall;
  assign FlushD = (pcWrPending | PCSrcW | branchEff) & ~StallD;

`ifdef HAZARD_STAT_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic anyFlush;
  assign anyFlush = FlushD | FlushE | FlushM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (StatClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != STAT_MAX)) StallCnt <= StallCnt + STAT_W'(1);
      if (anyFlush && (FlushCnt != STAT_MAX)) FlushCnt <= FlushCnt + STAT_W'(1);
    end
  end
`else
  logic unusedStatClr;
  assign unusedStatClr = StatClr;
  assign StallCnt      = '0;
  assign FlushCnt      = '0;
`endif

endmodule
